// File: rtl/hilo_unit_pkg.sv
// Shared definitions for the HI/LO register unit: op and state encodings, default width.
package hilo_unit_pkg;

  localparam int unsigned DataWDefault = 32;

  typedef enum logic [2:0] {
    OpNop  = 3'd0,
    OpMul  = 3'd1,
    OpMadd = 3'd2,
    OpMsub = 3'd3,
    OpMthi = 3'd4,
    OpMtlo = 3'd5
  } hilo_op_e;

  typedef enum logic [1:0] {
    StIdle,
    StMulWait,
    StAcc,
    StDrain
  } hilo_state_e;

  function automatic logic is_mul_op(input logic [2:0] op);
    return (op == OpMul) || (op == OpMadd) || (op == OpMsub);
  endfunction

endpackage

// File: rtl/hilo_acc.sv
// Wide add/sub of the HI:LO accumulator and a product, with an optional product register
// so the carry chain gets a cycle of its own.
module hilo_acc #(
  parameter int unsigned W   = 64,
  parameter bit          REG = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         sub,
  input  logic [W-1:0] acc_in,
  input  logic [W-1:0] p_in,
  output logic [W-1:0] result
);

  logic [W-1:0] p_op;

  if (REG) begin : g_reg
    logic [W-1:0] p_q;

    always_ff @(posedge clk) begin
      if (rst) begin
        p_q <= '0;
      end else if (load) begin
        p_q <= p_in;
      end
    end

    assign p_op = p_q;
  end else begin : g_comb
    assign p_op = p_in;
  end

  // Modulo 2*DATA_W: carry/borrow out is dropped.
  assign result = sub ? (acc_in - p_op) : (acc_in + p_op);

endmodule

// File: rtl/hilo_unit.sv
// HI/LO architectural registers: issues multiplies to the multiply controller, commits the
// product (or accumulates it) and stalls execute while an operation is in flight.
module hilo_unit
  import hilo_unit_pkg::*;
#(
  parameter int unsigned DATA_W  = DataWDefault,
  parameter bit          ACC_REG = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                op_valid,
  input  logic [2:0]          op,
  input  logic                op_sign,
  input  logic [DATA_W-1:0]   wdata,
  input  logic                flush,
  input  logic                is_busbusy,
  input  logic [2*DATA_W-1:0] mult_p,
  input  logic                mult_over,
  output logic                mult_start,
  output logic                mult_sign,
  output logic [DATA_W-1:0]   hi,
  output logic [DATA_W-1:0]   lo,
  output logic                busy
);

  hilo_state_e         state_q;
  logic [2:0]          op_q;
  logic                sign_q;
  logic [DATA_W-1:0]   hi_q;
  logic [DATA_W-1:0]   lo_q;
  logic [2*DATA_W-1:0] acc_res;

  logic idle;
  logic issue_mul;
  logic issue_mthi;
  logic issue_mtlo;
  logic commit;
  logic in_mul;

  assign idle       = (state_q == StIdle);
  assign issue_mul  = idle && op_valid && !flush && is_mul_op(op);
  assign issue_mthi = idle && op_valid && !flush && (op == OpMthi);
  assign issue_mtlo = idle && op_valid && !flush && (op == OpMtlo);
  assign commit     = mult_over && !is_busbusy;
  assign in_mul     = (state_q == StMulWait) || (state_q == StDrain);

  hilo_acc #(
    .W  (2 * DATA_W),
    .REG(ACC_REG)
  ) u_acc (
    .clk   (clk),
    .rst   (rst),
    .load  ((state_q == StMulWait) && commit),
    .sub   (op_q == OpMsub),
    .acc_in({hi_q, lo_q}),
    .p_in  (mult_p),
    .result(acc_res)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      op_q    <= OpNop;
      sign_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (issue_mul) begin
            state_q <= StMulWait;
            op_q    <= op;
            sign_q  <= op_sign;
          end else if (issue_mthi) begin
            hi_q <= wdata;
          end else if (issue_mtlo) begin
            lo_q <= wdata;
          end
        end
        StMulWait: begin
          // A flush that coincides with mult_over has nothing left to drain.
          if (flush) begin
            state_q <= mult_over ? StIdle : StDrain;
          end else if (commit) begin
            if (op_q == OpMul) begin
              {hi_q, lo_q} <= mult_p;
              state_q      <= StIdle;
            end else if (ACC_REG) begin
              state_q <= StAcc;
            end else begin
              {hi_q, lo_q} <= acc_res;
              state_q      <= StIdle;
            end
          end
        end
        StAcc: begin
          {hi_q, lo_q} <= acc_res;
          state_q      <= StIdle;
        end
        StDrain: begin
          if (mult_over) begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign mult_start = issue_mul || in_mul;
  assign mult_sign  = issue_mul ? op_sign : (in_mul ? sign_q : 1'b0);
  assign busy       = !idle || issue_mul;
  assign hi         = hi_q;
  assign lo         = lo_q;

endmodule
